// File: rtl/nz_lane_sequencer.sv
// nz_lane_sequencer
//   Serializes one group of four data lanes into a stream of only the lanes
//   flagged nonzero in the group's mask. The lowest index is emitted first.
//   The lane index travels with each beat and doubles as the select of the
//   downstream 4:1 lane mux. Groups with an all-zero mask are consumed
//   without producing a beat. A wrapping group counter is kept for debug.
//
// Parameters
//   DATA_W   width of one lane
//   CNT_W    width of the debug group counter
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream group valid
//   in_ready   group accepted when in_valid & in_ready
//   in_data    four lanes, lane k at [k*DATA_W +: DATA_W]
//   in_mask    bit k set = lane k is nonzero and must be emitted
//   out_valid  output beat valid
//   out_ready  beat consumed when out_valid & out_ready
//   out_data   value of the selected lane (0 when idle)
//   out_idx    lane index of the current beat / downstream mux select
//   out_last   current beat is the final nonzero lane of its group
//   grp_cnt    groups accepted since reset, mod 2^CNT_W
module nz_lane_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] in_data,
    input  logic [3:0]          in_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_idx,
    output logic                out_last,
    output logic [CNT_W-1:0]    grp_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                   state_reg;
    logic [3:0]               rem_reg;
    logic [CNT_W-1:0]         grp_cnt_reg;
    logic [3:0][DATA_W-1:0]   data_q;

    logic [1:0] cur_idx;
    logic       rem_one;
    logic       emit;
    logic       in_fire;
    logic       out_fire;
    logic       load;

    // Lowest set bit of the remaining mask selects the current lane.
    always_comb begin
        cur_idx = 2'd0;
        if (rem_reg[0])      cur_idx = 2'd0;
        else if (rem_reg[1]) cur_idx = 2'd1;
        else if (rem_reg[2]) cur_idx = 2'd2;
        else if (rem_reg[3]) cur_idx = 2'd3;
    end

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign rem_one = (rem_reg != 4'd0) && ((rem_reg & (rem_reg - 4'd1)) == 4'd0);

    assign emit      = (state_reg == EMIT);
    assign out_valid = emit;
    assign out_last  = emit & rem_one;
    assign out_idx   = emit ? cur_idx : 2'd0;
    assign out_data  = emit ? data_q[cur_idx] : '0;

    // In EMIT a new group may only enter while the last beat is leaving,
    // which gives back-to-back groups with no bubble.
    assign in_ready = ~emit | (rem_one & out_ready);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = emit & out_ready;
    assign load     = in_fire & (|in_mask);
    assign grp_cnt  = grp_cnt_reg;

    // Per-lane holding registers, loaded together when a nonzero group enters.
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        logic [DATA_W-1:0] lane_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_reg <= '0;
            end else if (load) begin
                lane_reg <= in_data[gi*DATA_W +: DATA_W];
            end
        end

        assign data_q[gi] = lane_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rem_reg     <= 4'd0;
            grp_cnt_reg <= '0;
        end else begin
            if (in_fire) begin
                grp_cnt_reg <= grp_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (load) begin
                        rem_reg   <= in_mask;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (!rem_one) begin
                            rem_reg <= rem_reg & ~(4'b0001 << cur_idx);
                        end else if (load) begin
                            rem_reg <= in_mask;
                        end else begin
                            // Zero-mask group or no group: nothing left to emit.
                            rem_reg   <= 4'd0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    rem_reg   <= 4'd0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nz_lane_sequencer.sv
module tb_nz_lane_sequencer;

    localparam int DATA_W = 32;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_mask;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_idx;
    logic                out_last;
    logic [15:0]         grp_cnt;

    // Narrow-counter copy driven by the same stimulus, to see the wrap.
    logic                n_in_ready;
    logic                n_out_valid;
    logic [DATA_W-1:0]   n_out_data;
    logic [1:0]          n_out_idx;
    logic                n_out_last;
    logic [1:0]          n_grp_cnt;

    int n_checks;
    int n_pass;

    nz_lane_sequencer #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .grp_cnt(grp_cnt)
    );

    nz_lane_sequencer #(.DATA_W(DATA_W), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .out_idx(n_out_idx),
        .out_last(n_out_last), .grp_cnt(n_grp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [1:0] idx,
                               input logic [DATA_W-1:0] data, input logic last);
        $display("beat %s: valid=%0b idx=%0d data=0x%0h last=%0b",
                 tag, out_valid, out_idx, out_data, out_last);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        check_eq({tag, ".idx"},   64'(out_idx),   64'(idx));
        check_eq({tag, ".data"},  64'(out_data),  64'(data));
        check_eq({tag, ".last"},  64'(out_last),  64'(last));
    endtask

    task automatic expect_idle(input string tag);
        $display("idle %s: valid=%0b idx=%0d data=0x%0h", tag, out_valid, out_idx, out_data);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'(1'b0));
        check_eq({tag, ".idx"},   64'(out_idx),   64'(2'd0));
        check_eq({tag, ".data"},  64'(out_data),  64'(0));
    endtask

    // Presents one group for a single edge; caller guarantees in_ready.
    task automatic send_group(input logic [DATA_W-1:0] l0, input logic [DATA_W-1:0] l1,
                              input logic [DATA_W-1:0] l2, input logic [DATA_W-1:0] l3,
                              input logic [3:0] m);
        $display("group: lanes {0x%0h,0x%0h,0x%0h,0x%0h} mask %b", l0, l1, l2, l3, m);
        in_valid = 1'b1;
        in_data  = {l3, l2, l1, l0};
        in_mask  = m;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = 4'd0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_eq("rst.valid", 64'(out_valid), 64'(0));
        check_eq("rst.last",  64'(out_last),  64'(0));
        check_eq("rst.idx",   64'(out_idx),   64'(0));
        check_eq("rst.data",  64'(out_data),  64'(0));
        check_eq("rst.cnt",   64'(grp_cnt),   64'(0));
        rst_n = 1'b1;
        #1;
        check_eq("rst.in_ready", 64'(in_ready), 64'(1));
        tick();

        // Full group, continuous out_ready
        send_group(32'h0, 32'h1, 32'h2, 32'h3, 4'b1111);
        check_eq("full.cnt", 64'(grp_cnt), 64'(1));
        expect_beat("full0", 2'd0, 32'h0, 1'b0);
        check_eq("full0.in_ready", 64'(in_ready), 64'(0));
        tick();
        expect_beat("full1", 2'd1, 32'h1, 1'b0);
        tick();
        expect_beat("full2", 2'd2, 32'h2, 1'b0);
        tick();
        expect_beat("full3", 2'd3, 32'h3, 1'b1);
        check_eq("full3.in_ready", 64'(in_ready), 64'(1));
        tick();
        expect_idle("full.end");

        // Sparse group
        send_group(32'habcd, 32'h1234, 32'ha1b1, 32'hc2d2, 4'b1010);
        expect_beat("sparse0", 2'd1, 32'h1234, 1'b0);
        tick();
        expect_beat("sparse1", 2'd3, 32'hc2d2, 1'b1);
        tick();
        expect_idle("sparse.end");
        check_eq("sparse.cnt", 64'(grp_cnt), 64'(2));

        // Backpressure on the first beat
        out_ready = 1'b0;
        send_group(32'h11, 32'h22, 32'h33, 32'h44, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            expect_beat("bp_hold", 2'd0, 32'h11, 1'b0);
            check_eq("bp_hold.in_ready", 64'(in_ready), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        #1;
        expect_beat("bp0", 2'd0, 32'h11, 1'b0);
        check_eq("bp0.in_ready", 64'(in_ready), 64'(0));
        tick();
        expect_beat("bp1", 2'd2, 32'h33, 1'b1);
        out_ready = 1'b0;
        #1;
        check_eq("bp1.in_ready_low", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        expect_idle("bp.end");

        // Back-to-back: A (mask 1000) then B (mask 0001), in_valid held high
        in_valid = 1'b1;
        in_data  = {32'ha3, 32'h0, 32'h0, 32'h0};
        in_mask  = 4'b1000;
        tick();
        in_data  = {32'h0, 32'h0, 32'h0, 32'hb0};
        in_mask  = 4'b0001;
        #1;
        expect_beat("b2bA", 2'd3, 32'ha3, 1'b1);
        check_eq("b2bA.in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        expect_beat("b2bB", 2'd0, 32'hb0, 1'b1);
        check_eq("b2b.cnt", 64'(grp_cnt), 64'(5));
        tick();
        expect_idle("b2b.end");

        // Zero-mask group between two single-beat groups
        send_group(32'h0, 32'h0, 32'h77, 32'h0, 4'b0100);
        expect_beat("z1", 2'd2, 32'h77, 1'b1);
        tick();
        expect_idle("z1.end");
        send_group(32'hdead, 32'hbeef, 32'h5, 32'h6, 4'b0000);
        expect_idle("zero");
        check_eq("zero.in_ready", 64'(in_ready), 64'(1));
        send_group(32'h99, 32'h0, 32'h0, 32'h0, 4'b0001);
        expect_beat("z3", 2'd0, 32'h99, 1'b1);
        check_eq("zero.cnt", 64'(grp_cnt), 64'(8));
        // Zero-mask group taken while the last beat leaves: back to IDLE
        in_valid = 1'b1;
        in_data  = '0;
        in_mask  = 4'b0000;
        tick();
        in_valid = 1'b0;
        expect_idle("zlast");
        check_eq("zlast.cnt", 64'(grp_cnt), 64'(9));
        check_eq("zlast.cnt2", 64'(n_grp_cnt), 64'(1));

        // Reset mid-group
        send_group(32'h10, 32'h11, 32'h12, 32'h13, 4'b1111);
        expect_beat("mr0", 2'd0, 32'h10, 1'b0);
        tick();
        expect_beat("mr1", 2'd1, 32'h11, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mr.async_valid", 64'(out_valid), 64'(0));
        check_eq("mr.cnt", 64'(grp_cnt), 64'(0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_idle("mr.after");
        end

        // Five zero-mask groups: narrow counter wraps to 1
        in_valid = 1'b1;
        in_data  = '0;
        in_mask  = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        $display("wrap: grp_cnt=%0d grp_cnt(CNT_W=2)=%0d", grp_cnt, n_grp_cnt);
        check_eq("wrap.cnt16", 64'(grp_cnt), 64'(5));
        check_eq("wrap.cnt2", 64'(n_grp_cnt), 64'(1));
        expect_idle("wrap.end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nz_lane_sequencer.md
# nz_lane_sequencer

Serializing stage that sits directly upstream of the 4:1 lane mux (`mux_4_1`) in the indexed row-shift path. Accepts one group of four data lanes plus a 4-bit nonzero mask per handshake. Emits only the masked-in lanes, lowest index first, one per accepted output beat. Drives the mux select alongside each beat. Mask-zero groups are consumed silently, and a wrapping group counter is kept for debug.

## Interface
- `DATA_W`, default 32: width of one lane.
- `CNT_W`, default 16: width of the group counter.
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: upstream group valid.
- `in_ready`  out  1: group accepted when `in_valid & in_ready`.
- `in_data`  in  4*DATA_W: lane k at bits [k*DATA_W +: DATA_W].
- `in_mask`  in  4: bit k = lane k is nonzero.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: beat consumed when `out_valid & out_ready`.
- `out_data`  out  DATA_W: selected lane value.
- `out_idx`  out  2: lane index of current beat; also the downstream mux select.
- `out_last`  out  1: current beat is the final nonzero of its group.
- `grp_cnt`  out  CNT_W: number of groups accepted since reset, mod 2^CNT_W.

## Operation
- Two states: IDLE and EMIT.
- Group registers hold `data_q[3:0]` and `rem_q[3:0]` (the remaining mask).
- IDLE:
  - `in_ready` = 1, `out_valid` = 0.
  - On accept with `in_mask` != 0: load `data_q` and `rem_q` from the inputs, go to EMIT.
  - On accept with `in_mask` == 0: stay in IDLE, emit no beat, still increment `grp_cnt`.
- EMIT:
  - `out_valid` = 1.
  - `out_idx` = priority encode of `rem_q`, lowest set bit first.
  - `out_data` = `data_q[out_idx]`.
  - `out_last` = 1 iff exactly one bit of `rem_q` is set.
- Beat accepted, not last: clear bit `out_idx` of `rem_q`, stay in EMIT.
- Beat accepted and last: `in_ready` = `out_ready` combinationally, so the next group can be taken in the same cycle.
  - New group accepted with nonzero mask: load it, stay in EMIT (back-to-back, no bubble).
  - New group accepted with zero mask: count it, go to IDLE.
  - No new group: go to IDLE.
- EMIT with no beat accepted: `in_ready` = 0.
- While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_idx` and `out_last` are held stable.
- `out_data` and `out_idx` are don't-care when `out_valid` = 0. The implementation drives `out_idx` = 0 and `out_data` = 0 then.
- `grp_cnt` increments on every input accept and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - State = IDLE; `rem_q` = 0; `data_q` = 0; `grp_cnt` = 0.
  - `out_valid` = 0, `out_last` = 0, `out_idx` = 0, `out_data` = 0.
  - `in_ready` = 1 once `rst_n` is high.
- Reset asserted mid-group: the remaining beats are discarded and no further beat is emitted. After deassertion the block is in IDLE.
- Latency: first beat is valid the cycle after the input accept (registered). There is no combinational path from `in_data` to `out_data`.
- Throughput: a group with k nonzeros occupies exactly k output cycles when `out_ready` = 1 continuously. A zero-mask group costs one cycle in IDLE and none in EMIT.
- `in_ready` depends combinationally on `out_ready` only in EMIT on the last beat. There is no path from `in_valid` to `out_valid` within the same cycle.
- `out_idx` is registered-state-derived (decoded from `rem_q`), stable for the whole cycle, and safe to drive the mux `sel` directly.

## Test plan
- Reset, then one group: lanes {0x0,0x1,0x2,0x3}, mask 4'b1111, `out_ready` = 1 → beats idx 0,1,2,3 on four consecutive cycles, data 0x0..0x3, `out_last` only on idx 3. `grp_cnt` = 1.
- Sparse group: lanes {0xabcd,0x1234,0xa1b1,0xc2d2}, mask 4'b1010 → two beats: (idx 1, 0x1234), then (idx 3, 0xc2d2, last).
- Backpressure: mask 4'b0101 with `out_ready` low for 3 cycles on the first beat → (idx 0) held stable for all 3 cycles, `in_ready` = 0 throughout. Then idx 0, then (idx 2, last).
- Back-to-back: group A mask 4'b1000 then group B mask 4'b0001, `in_valid` held high → A idx 3 (last) in cycle n, B idx 0 (last) in cycle n+1, no bubble between them.
- Zero mask: mask 4'b0000 between two single-beat groups → no output beat for it, `grp_cnt` advances by 3 in total. With CNT_W = 2, five groups → `grp_cnt` wraps to 1.
- Reset mid-group: mask 4'b1111, assert `rst_n` = 0 after the second beat → `out_valid` drops to 0 asynchronously, and no idx 2/3 beats appear after release.
